// File: rtl/tff_count_monitor.sv
// Sequence checker for a 4-bit T-flip-flop counter: flags legal +1 steps and wraps,
// counts wraps with saturation, and latches the first skip / out-of-range / stall fault.
module tff_count_monitor #(
   parameter int MAX_VAL   = 15,
   parameter int WRAP_W    = 8,
   parameter int STALL_MAX = 64
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [3:0]        Q,
   input  logic              EN,
   input  logic              CLR,
   output logic              STEP,
   output logic              WRAP,
   output logic [WRAP_W-1:0] WRAP_CNT,
   output logic              ERR,
   output logic [1:0]        ERR_CODE,
   output logic [1:0]        STATE,
   output logic [3:0]        Q_PREV
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      TRACK = 2'b01,
      FAULT = 2'b10
   } state_t;

   localparam logic [3:0]        MAX_Q     = 4'(MAX_VAL);
   localparam logic [7:0]        STALL_LIM = 8'(STALL_MAX);
   localparam logic [WRAP_W-1:0] WCNT_SAT  = {WRAP_W{1'b1}};

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_SKIP  = 2'b01;
   localparam logic [1:0] CODE_RANGE = 2'b10;
   localparam logic [1:0] CODE_STALL = 2'b11;

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        stall_cnt;
   logic [7:0]        stall_nxt;
   logic [7:0]        stall_inc;
   logic [3:0]        q_inc;
   logic              q_oor;
   logic              q_same;
   logic              q_step;
   logic              q_wrap;
   logic              stall_hit;
   logic              step_nxt;
   logic              wrap_nxt;
   logic              err_nxt;
   logic [1:0]        code_nxt;
   logic [WRAP_W-1:0] wcnt_nxt;
   logic [3:0]        qprev_nxt;

   // Classification of the current sample against the previous one; the
   // increment deliberately wraps in 4 bits so MAX_VAL=15 only wraps via q_wrap.
   assign q_inc     = Q_PREV + 4'd1;
   assign q_oor     = (Q > MAX_Q);
   assign q_same    = (Q == Q_PREV);
   assign q_step    = (Q_PREV < MAX_Q) && (Q == q_inc);
   assign q_wrap    = (Q_PREV == MAX_Q) && (Q == 4'd0);
   assign stall_inc = stall_cnt + 8'd1;
   assign stall_hit = (stall_inc == STALL_LIM);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (CLR) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (EN) state_nxt = TRACK;
            end
            TRACK: begin
               if (EN) begin
                  if (q_oor)                   state_nxt = FAULT;
                  else if (q_same)             state_nxt = stall_hit ? FAULT : TRACK;
                  else if (q_step || q_wrap)   state_nxt = TRACK;
                  else                         state_nxt = FAULT;
               end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs; pulses default low and everything
   // else holds, so EN=0 and FAULT fall out of the defaults.
   always_comb begin
      step_nxt  = 1'b0;
      wrap_nxt  = 1'b0;
      err_nxt   = ERR;
      code_nxt  = ERR_CODE;
      wcnt_nxt  = WRAP_CNT;
      stall_nxt = stall_cnt;
      qprev_nxt = Q_PREV;
      if (CLR) begin
         err_nxt   = 1'b0;
         code_nxt  = CODE_NONE;
         wcnt_nxt  = '0;
         stall_nxt = 8'd0;
         qprev_nxt = Q;
      end else if (EN) begin
         case (state)
            IDLE: begin
               qprev_nxt = Q;
            end
            TRACK: begin
               qprev_nxt = Q;
               if (q_oor) begin
                  err_nxt  = 1'b1;
                  code_nxt = CODE_RANGE;
               end else if (q_same) begin
                  stall_nxt = stall_inc;
                  if (stall_hit) begin
                     err_nxt  = 1'b1;
                     code_nxt = CODE_STALL;
                  end
               end else if (q_step) begin
                  step_nxt  = 1'b1;
                  stall_nxt = 8'd0;
               end else if (q_wrap) begin
                  step_nxt  = 1'b1;
                  wrap_nxt  = 1'b1;
                  stall_nxt = 8'd0;
                  if (WRAP_CNT != WCNT_SAT) wcnt_nxt = WRAP_CNT + 1'b1;
               end else begin
                  err_nxt  = 1'b1;
                  code_nxt = CODE_SKIP;
               end
            end
            FAULT: begin
               qprev_nxt = Q;
            end
            default: begin
               qprev_nxt = Q_PREV;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         STEP      <= 1'b0;
         WRAP      <= 1'b0;
         WRAP_CNT  <= '0;
         ERR       <= 1'b0;
         ERR_CODE  <= CODE_NONE;
         stall_cnt <= 8'd0;
         Q_PREV    <= 4'd0;
      end else begin
         STEP      <= step_nxt;
         WRAP      <= wrap_nxt;
         WRAP_CNT  <= wcnt_nxt;
         ERR       <= err_nxt;
         ERR_CODE  <= code_nxt;
         stall_cnt <= stall_nxt;
         Q_PREV    <= qprev_nxt;
      end
   end

   assign STATE = state;

endmodule
